shift_rows_pipe: RTL and testbench

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/aes_pkg.sv | 39 +++
 rtl/shift_rows_perm.sv | 33 +++
 rtl/shift_rows_pipe.sv | 159 +++++++++++++++
 tb/tb_shift_rows_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared ShiftRows constants, buffer state encodings, row-offset
//               table and NB legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam logic C_MODE_FWD = 1'b0;
    localparam logic C_MODE_INV = 1'b1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Rijndael row rotation: the wide 256-bit block spreads rows 2 and 3 further.
    function automatic int row_off(input int nb, input int row);
        case (row)
            0:       return 0;
            1:       return 1;
            2:       return (nb == 8) ? 3 : 2;
            default: return (nb == 8) ? 4 : 3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rows_perm.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_perm
// Description : Pure combinational (Inverse)ShiftRows byte permutation.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] data,
    input  logic             inv,
    output logic [32*NB-1:0] result
);

    // Word c sits at the MSB end for c=0; row 0 is the top byte of each word.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF   = row_off(NB, r);
            localparam int SRC_F = (c + OFF) % NB;
            localparam int SRC_I = (c - OFF + NB) % NB;
            localparam int DST   = 32*NB - 1 - 32*c - 8*r;
            localparam int BIT_F = 32*NB - 1 - 32*SRC_F - 8*r;
            localparam int BIT_I = 32*NB - 1 - 32*SRC_I - 8*r;

            assign result[DST -: 8] = (inv == C_MODE_INV) ? data[BIT_I -: 8]
                                                          : data[BIT_F -: 8];
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_pipe
// Description : One-stage valid/ready ShiftRows pipeline with transfer counter.
//               Define SHIFT_ROWS_SKID_EN for a two-entry skid buffer with a
//               registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [32*NB-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data,
    output logic             out_inv,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int W = 32 * NB;

    if (!nb_legal(NB)) begin : g_nb_illegal
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0]     w_perm;
    logic             w_accept;
    logic             w_xfer;
    logic [CNT_W-1:0] blk_cnt_q;

    shift_rows_perm #(.NB(NB)) u_perm (
        .data   (in_data),
        .inv    (in_inv),
        .result (w_perm)
    );

    assign w_accept = in_valid && in_ready;
    assign w_xfer   = out_valid && out_ready;

`ifdef SHIFT_ROWS_SKID_EN
    skid_state_t state_q, state_d;
    logic [W-1:0] head_q, head_d, skid_q, skid_d;
    logic         head_inv_q, head_inv_d, skid_inv_q, skid_inv_d;
    logic         rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SKID_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            head_inv_q <= C_MODE_FWD;
            skid_inv_q <= C_MODE_FWD;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_inv_q <= head_inv_d;
            skid_inv_q <= skid_inv_d;
            rdy_q      <= (state_d != SKID_TWO);
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        head_inv_d = head_inv_q;
        skid_inv_d = skid_inv_q;
        case (state_q)
            SKID_EMPTY: begin
                if (w_accept) begin
                    state_d    = SKID_ONE;
                    head_d     = w_perm;
                    head_inv_d = in_inv;
                end
            end
            SKID_ONE: begin
                if (w_accept && w_xfer) begin
                    head_d     = w_perm;
                    head_inv_d = in_inv;
                end else if (w_accept) begin
                    state_d    = SKID_TWO;
                    skid_d     = w_perm;
                    skid_inv_d = in_inv;
                end else if (w_xfer) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (w_xfer) begin
                    state_d    = SKID_ONE;
                    head_d     = skid_q;
                    head_inv_d = skid_inv_q;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // The flop alone would read 1 during reset; rst gates it low.
    assign in_ready  = rdy_q && !rst;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = head_q;
    assign out_inv   = head_inv_q;
`else
    buf_state_t   state_q, state_d;
    logic [W-1:0] data_q;
    logic         inv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            data_q  <= '0;
            inv_q   <= C_MODE_FWD;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                data_q <= w_perm;
                inv_q  <= in_inv;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: if (w_accept)             state_d = BUF_FULL;
            BUF_FULL:  if (w_xfer && !w_accept)  state_d = BUF_EMPTY;
            default:                             state_d = BUF_EMPTY;
        endcase
    end

    assign out_valid = (state_q == BUF_FULL);
    assign in_ready  = !rst && (!out_valid || out_ready);
    assign out_data  = data_q;
    assign out_inv   = inv_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (w_xfer) begin
            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
        end
    end

    assign blk_cnt = blk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rows_pipe
// Description : Scoreboard bench for shift_rows_pipe (NB=4/CNT_W=4 and NB=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rows_pipe;

`ifdef SHIFT_ROWS_SKID_EN
    localparam int C_STALL_HELD = 2;
`else
    localparam int C_STALL_HELD = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
    logic [127:0] a_in_data, a_out_data;
    logic [3:0]   a_blk_cnt;
    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
    logic [255:0] b_in_data, b_out_data;
    logic [15:0]  b_blk_cnt;

    shift_rows_pipe #(.NB(4), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_inv(a_out_inv), .blk_cnt(a_blk_cnt)
    );

    shift_rows_pipe #(.NB(8), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_inv(b_out_inv), .blk_cnt(b_blk_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] a_exp_data;
    logic         a_exp_inv;
    logic [127:0] a_qd[$];
    logic         a_qi[$];
    int           a_acc_cnt = 0;
    logic [3:0]   a_cnt_model = '0;
    logic         a_prev_hold = 1'b0;
    logic [127:0] a_prev_data;
    logic         a_prev_inv;

    logic [255:0] b_exp_data;
    logic         b_exp_inv;
    logic [255:0] b_qd[$];
    logic         b_qi[$];
    logic [15:0]  b_cnt_model = '0;

    logic [127:0] a_vin[6], a_vexp[6];
    logic         a_vinv[6];

    localparam logic [255:0] C_VB = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] C_FB = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;
    localparam logic [255:0] C_IB = 256'h001d161304011a1708051e1b0c09021f100d060314110a0718150e0b1c19120f;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected responses are queued on the negedge before the accepting edge.
    always @(negedge clk) begin
        if (!rst && a_in_valid && a_in_ready) begin
            a_qd.push_back(a_exp_data);
            a_qi.push_back(a_exp_inv);
            a_acc_cnt++;
        end
        if (!rst && b_in_valid && b_in_ready) begin
            b_qd.push_back(b_exp_data);
            b_qi.push_back(b_exp_inv);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            a_qd.delete();
            a_qi.delete();
            a_cnt_model = '0;
            a_prev_hold = 1'b0;
        end else begin
            if (a_prev_hold) begin
                check("a_hold_valid", 256'(a_out_valid), 256'(1));
                check("a_hold_data", 256'(a_out_data), 256'(a_prev_data));
                check("a_hold_inv", 256'(a_out_inv), 256'(a_prev_inv));
            end
            if (a_out_valid && a_out_ready) begin
                if (a_qd.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_unexpected_out: got %0h expected none", a_out_data);
                end else begin
                    check("a_data", 256'(a_out_data), 256'(a_qd.pop_front()));
                    check("a_inv", 256'(a_out_inv), 256'(a_qi.pop_front()));
                end
                check("a_blk_cnt", 256'(a_blk_cnt), 256'(a_cnt_model));
                a_cnt_model = a_cnt_model + 4'd1;
            end
            a_prev_hold = a_out_valid && !a_out_ready;
            a_prev_data = a_out_data;
            a_prev_inv  = a_out_inv;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_qd.delete();
            b_qi.delete();
            b_cnt_model = '0;
        end else if (b_out_valid && b_out_ready) begin
            if (b_qd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_out: got %0h expected none", b_out_data);
            end else begin
                check("b_data", b_out_data, b_qd.pop_front());
                check("b_inv", 256'(b_out_inv), 256'(b_qi.pop_front()));
            end
            check("b_blk_cnt", 256'(b_blk_cnt), 256'(b_cnt_model));
            b_cnt_model = b_cnt_model + 16'd1;
        end
    end

    task automatic send_a(input logic [127:0] d, input logic inv, input logic [127:0] e);
        logic acc;
        acc        = 1'b0;
        a_in_data  = d;
        a_in_inv   = inv;
        a_exp_data = e;
        a_exp_inv  = inv;
        a_in_valid = 1'b1;
        for (int k = 0; k < 60 && !acc; k++) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        a_in_data  = {$urandom, $urandom, $urandom, $urandom};
        a_in_inv   = 1'($urandom);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_send_timeout: got no accept expected accept for %0h", d);
        end
    endtask

    task automatic send_b(input logic [255:0] d, input logic inv, input logic [255:0] e);
        logic acc;
        acc        = 1'b0;
        b_in_data  = d;
        b_in_inv   = inv;
        b_exp_data = e;
        b_exp_inv  = inv;
        b_in_valid = 1'b1;
        for (int k = 0; k < 60 && !acc; k++) begin
            @(negedge clk);
            acc = b_in_ready;
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        b_in_data  = {8{$urandom}};
        b_in_inv   = 1'($urandom);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_send_timeout: got no accept expected accept for %0h", d);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (a_qd.size() != 0 || b_qd.size() != 0); k++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check("drain_pending", 256'(a_qd.size() + b_qd.size()), 256'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_in_ready"}, 256'(a_in_ready), 256'(0));
        check({tag, "_a_out_valid"}, 256'(a_out_valid), 256'(0));
        check({tag, "_a_out_data"}, 256'(a_out_data), 256'(0));
        check({tag, "_a_out_inv"}, 256'(a_out_inv), 256'(0));
        check({tag, "_a_blk_cnt"}, 256'(a_blk_cnt), 256'(0));
        check({tag, "_b_in_ready"}, 256'(b_in_ready), 256'(0));
        check({tag, "_b_out_valid"}, 256'(b_out_valid), 256'(0));
        check({tag, "_b_out_data"}, b_out_data, 256'(0));
        check({tag, "_b_blk_cnt"}, 256'(b_blk_cnt), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        a_vin[0] = 128'h000102030405060708090a0b0c0d0e0f; a_vinv[0] = 1'b0;
        a_vexp[0] = 128'h00050a0f04090e03080d02070c01060b;
        a_vin[1] = 128'h000102030405060708090a0b0c0d0e0f; a_vinv[1] = 1'b1;
        a_vexp[1] = 128'h000d0a0704010e0b0805020f0c090603;
        a_vin[2] = 128'h00112233445566778899aabbccddeeff; a_vinv[2] = 1'b0;
        a_vexp[2] = 128'h0055aaff4499ee3388dd2277cc1166bb;
        a_vin[3] = 128'h00112233445566778899aabbccddeeff; a_vinv[3] = 1'b1;
        a_vexp[3] = 128'h00ddaa774411eebb885522ffcc996633;
        a_vin[4] = 128'h00050a0f04090e03080d02070c01060b; a_vinv[4] = 1'b1;
        a_vexp[4] = 128'h000102030405060708090a0b0c0d0e0f;
        a_vin[5] = 128'h00ddaa774411eebb885522ffcc996633; a_vinv[5] = 1'b0;
        a_vexp[5] = 128'h00112233445566778899aabbccddeeff;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        a_exp_data = '0; a_exp_inv = 1'b0; b_exp_data = '0; b_exp_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b0;

        // Directed vectors, back to back
        for (int i = 0; i < 6; i++) send_a(a_vin[i], a_vinv[i], a_vexp[i]);
        send_b(C_VB, 1'b0, C_FB);
        send_b(C_FB, 1'b1, C_VB);
        send_b(C_VB, 1'b1, C_IB);
        drain();

        // Downstream stall with continuous offers
        a_out_ready = 1'b0;
        acc0 = a_acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send_a(a_vin[i], a_vinv[i], a_vexp[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("stall_held", 256'(a_acc_cnt - acc0), 256'(C_STALL_HELD));
                a_out_ready = 1'b1;
            end
        join
        drain();

        // Counter wrap: 17 transfers on a 4-bit counter
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst2");
        rst = 1'b0;
        for (int i = 0; i < 17; i++) send_a(a_vin[i % 6], a_vinv[i % 6], a_vexp[i % 6]);
        drain();
        check("cnt_wrap", 256'(a_blk_cnt), 256'(1));

        // Reset while a result is held
        a_out_ready = 1'b0;
        send_a(a_vin[0], a_vinv[0], a_vexp[0]);
        @(negedge clk);
        check("pre_rst_valid", 256'(a_out_valid), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 256'(a_out_valid), 256'(0));
        check("async_rst_cnt", 256'(a_blk_cnt), 256'(0));
        check("async_rst_data", 256'(a_out_data), 256'(0));
        check("async_rst_ready", 256'(a_in_ready), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        send_a(a_vin[2], a_vinv[2], a_vexp[2]);
        drain();
        check("post_rst_cnt", 256'(a_blk_cnt), 256'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
